regfile_wport_arbiter: RTL and testbench

- Shares the single register-file write port (we/wn/d) among NREQ writeback requesters, e.g. core ALU writeback, multiply/divide unit, debug port.
- Uses round-robin arbitration with a valid/ready handshake.
- Contains a sequenced clear engine that walks registers 1..31, writing zero, so software and debug can scrub the file without the async reset.
- Sits between the writeback sources and the register file; its rf_* outputs drive the register-file write port directly.

---
 rtl/regfile_wport_arbiter.sv | 144 ++++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wport_arbiter.sv
// ============================================================================
// Module  : regfile_wport_arbiter
// Brief   : Round-robin arbiter for the single register-file write port, with
//           a sequenced clear engine that zeroes r1..r31.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_wport_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_wn,
    input  logic [32*NREQ-1:0]   req_d,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic                 clr_done,
    output logic                 rf_we,
    output logic [4:0]           rf_wn,
    output logic [31:0]          rf_d
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [PTR_W:0] C_NREQ  = (PTR_W+1)'(NREQ);
    localparam logic [4:0]     C_FIRST = 5'd1;
    localparam logic [4:0]     C_LAST  = 5'd31;

    state_t               r_state, w_state_nxt;
    logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
    logic [4:0]           r_cnt, w_cnt_nxt;
    logic                 r_clr_done, w_clr_done_nxt;

    logic [2*NREQ-1:0]    w_dbl;
    logic [NREQ-1:0]      w_rot;
    logic                 w_found;
    logic [PTR_W-1:0]     w_off;
    logic [PTR_W:0]       w_sum;
    logic [PTR_W:0]       w_gidx;
    logic [PTR_W:0]       w_pinc;
    logic [PTR_W-1:0]     w_ptr_adv;
    logic [NREQ-1:0]      w_grant;
    logic [4:0]           w_sel_wn;
    logic [31:0]          w_sel_d;

    // Rotate so bit 0 is the requester at ptr; the first set bit is the winner.
    assign w_dbl = {req_valid, req_valid};
    assign w_rot = NREQ'(w_dbl >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = PTR_W'(k);
            end
        end
    end

    assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_gidx    = (w_sum >= C_NREQ) ? (w_sum - C_NREQ) : w_sum;
    assign w_pinc    = w_gidx + 1'b1;
    assign w_ptr_adv = (w_pinc == C_NREQ) ? '0 : w_pinc[PTR_W-1:0];

    always_comb begin
        w_grant  = '0;
        w_sel_wn = '0;
        w_sel_d  = '0;
        for (int j = 0; j < NREQ; j++) begin
            w_grant[j] = w_found && (w_gidx == (PTR_W+1)'(j));
            w_sel_wn   = w_sel_wn | ({5{w_grant[j]}}  & req_wn[5*j +: 5]);
            w_sel_d    = w_sel_d  | ({32{w_grant[j]}} & req_d[32*j +: 32]);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_cnt_nxt      = r_cnt;
        w_clr_done_nxt = 1'b0;
        req_ready      = '0;
        clr_busy       = 1'b0;
        rf_we          = 1'b0;
        rf_wn          = '0;
        rf_d           = '0;
        // Outputs are forced low for the whole time reset is applied.
        if (!clrn) begin
            unique case (r_state)
                S_IDLE: begin
                    if (clr_start) begin
                        w_state_nxt = S_CLEAR;
                        w_cnt_nxt   = C_FIRST;
                    end else if (w_found) begin
                        req_ready = w_grant;
                        rf_wn     = w_sel_wn;
                        rf_d      = w_sel_d;
                        rf_we     = (w_sel_wn != 5'd0);
                        w_ptr_nxt = w_ptr_adv;
                    end
                end
                S_CLEAR: begin
                    clr_busy = 1'b1;
                    rf_we    = 1'b1;
                    rf_wn    = r_cnt;
                    if (r_cnt == C_LAST) begin
                        w_state_nxt    = S_IDLE;
                        w_cnt_nxt      = C_FIRST;
                        w_clr_done_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 5'd1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_cnt      <= C_FIRST;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_clr_done <= w_clr_done_nxt;
        end
    end

    assign clr_done = r_clr_done;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wport_arbiter.sv
// ============================================================================
// Module  : tb_regfile_wport_arbiter
// Brief   : Self-checking bench: directed literal checks plus randomized
//           traffic compared every cycle against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wport_arbiter;

    localparam int NREQ  = 3;
    localparam int PTR_W = 2;

    logic                clk = 1'b0;
    logic                clrn = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [5*NREQ-1:0]   req_wn = '0;
    logic [32*NREQ-1:0]  req_d = '0;
    logic [NREQ-1:0]     req_ready;
    logic                clr_start = 1'b0;
    logic                clr_busy;
    logic                clr_done;
    logic                rf_we;
    logic [4:0]          rf_wn;
    logic [31:0]         rf_d;

    int errors = 0;
    int checks = 0;
    logic [NREQ-1:0] hs;

    regfile_wport_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .req_valid (req_valid),
        .req_wn    (req_wn),
        .req_d     (req_d),
        .req_ready (req_ready),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .rf_we     (rf_we),
        .rf_wn     (rf_wn),
        .rf_d      (rf_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: round-robin search from m_ptr, clear walks m_idx 1..31.
    int   m_ptr = 0;
    bit   m_clearing = 0;
    int   m_idx = 1;
    bit   m_done = 0;

    always @(negedge clk) begin
        logic [NREQ-1:0] e_ready;
        logic            e_we, e_busy, e_done;
        logic [4:0]      e_wn;
        logic [31:0]     e_d;
        int              g, i;
        e_ready = '0; e_we = 0; e_busy = 0; e_done = 0; e_wn = '0; e_d = '0;
        if (clrn) begin
            m_ptr = 0; m_clearing = 0; m_idx = 1; m_done = 0;
        end else begin
            e_done = m_done;
            m_done = 0;
            if (m_clearing) begin
                e_busy = 1; e_we = 1; e_wn = 5'(m_idx);
                if (m_idx == 31) begin
                    m_clearing = 0; m_idx = 1; m_done = 1;
                end else begin
                    m_idx = m_idx + 1;
                end
            end else if (clr_start) begin
                m_clearing = 1; m_idx = 1;
            end else begin
                g = -1;
                for (int k = 0; k < NREQ; k++) begin
                    i = (m_ptr + k) % NREQ;
                    if (g < 0 && req_valid[i]) g = i;
                end
                if (g >= 0) begin
                    e_ready[g] = 1'b1;
                    e_wn  = req_wn[5*g +: 5];
                    e_d   = req_d[32*g +: 32];
                    e_we  = (e_wn != 0);
                    m_ptr = (g + 1) % NREQ;
                end
            end
        end
        chk("model_ports", {21'd0, req_ready, rf_we, rf_wn, rf_d, clr_busy, clr_done},
                           {21'd0, e_ready, e_we, e_wn, e_d, e_busy, e_done});
    end

    task automatic step();
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] wn, input logic [31:0] d);
        req_valid[i]      = v;
        req_wn[5*i +: 5]  = wn;
        req_d[32*i +: 32] = d;
    endtask

    initial begin
        // Reset with requests pending: everything must stay low.
        req_valid = 3'b111;
        #2;
        chk("reset_outs", {req_ready, rf_we, rf_wn, rf_d, clr_busy, clr_done}, 43'd0);
        step();
        clrn = 1'b0;
        req_valid = '0;

        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        chk("single_ready", req_ready, 3'b010);
        chk("single_port", {rf_we, rf_wn, rf_d}, {1'b1, 5'd5, 32'hDEADBEEF});
        step();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(10 + i), 32'(100 + i));
        #1;
        chk("ptr_after_single", req_ready, 3'b100);
        step();

        for (int n = 0; n < 6; n++) begin
            #1;
            chk("rr_ready", req_ready, 3'b001 << (n % 3));
            chk("rr_wn", rf_wn, 5'(10 + n % 3));
            step();
        end

        req_valid = '0;
        set_req(0, 1'b1, 5'd0, 32'h1234);
        #1;
        chk("r0_ready", req_ready, 3'b001);
        chk("r0_we", rf_we, 1'b0);
        step();
        req_valid = 3'b011;
        #1;
        chk("r0_ptr_adv", req_ready, 3'b010);
        step();

        req_valid = '0;
        set_req(2, 1'b1, 5'd7, 32'hCAFE0007);
        clr_start = 1'b1;
        #1;
        chk("clr_start_nogrant", {req_ready, rf_we}, 4'd0);
        step();
        for (int k = 1; k <= 31; k++) begin
            clr_start = (k == 10);
            #1;
            chk("clr_write", {clr_busy, rf_we, rf_wn, rf_d, req_ready, clr_done},
                             {1'b1, 1'b1, 5'(k), 32'd0, 3'b000, 1'b0});
            step();
        end
        clr_start = 1'b0;
        #1;
        chk("clr_done_pulse", clr_done, 1'b1);
        chk("pending_grant", {req_ready, rf_we, rf_wn}, {3'b100, 1'b1, 5'd7});
        step();
        req_valid = '0;
        #1;
        chk("clr_done_single", {clr_done, clr_busy}, 2'b00);

        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int k = 1; k < 15; k++) step();
        #1;
        chk("mid_clear_wn", rf_wn, 5'd15);
        #1;
        clrn = 1'b1;
        #1;
        chk("async_abort", {rf_we, clr_busy}, 2'b00);
        step();
        clrn = 1'b0;
        req_valid = 3'b111;
        #1;
        chk("post_reset", {req_ready, clr_done, clr_busy}, {3'b001, 1'b0, 1'b0});
        step();
        #1;
        chk("post_reset_nodone", clr_done, 1'b0);

        // Randomized traffic: requests hold until their handshake completes.
        for (int n = 0; n < 600; n++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'b1, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom);
            end
            clr_start = !clr_start && ($urandom_range(0, 39) == 0);
            if (n == 300) begin
                #2 clrn = 1'b1;
                step();
                clrn = 1'b0;
            end
        end
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
